button_conditioner: RTL and testbench

- Front-end stage directly upstream of the volume controller.
- Takes raw, bouncing, asynchronous push-button inputs and synchronises and debounces them.
- Produces one-cycle up/down command pulses with press-and-hold auto-repeat, plus a toggled mode level.
- Outputs connect straight to the volume block's up, down and mode inputs.

---
 rtl/button_conditioner.sv | 128 ++++++++++++
 tb/tb_button_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronisers, per-button debounce, up/down
// press pulses with hold-to-repeat and conflict lockout, and a toggled mode level.
module button_conditioner #(
   parameter int DEBOUNCE = 4,
   parameter int HOLD     = 16,
   parameter int REPEAT   = 8,
   parameter int CNT_W    = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_mode,
   output logic up,
   output logic down,
   output logic mode
);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

   logic [2:0]       raw;
   logic [2:0]       sync_p0;
   logic [2:0]       sync_p1;
   logic [2:0]       stable_p2;
   logic [2:0]       stable_p3;
   logic [2:0]       rise;
   logic [CNT_W-1:0] db_cnt [3];
   logic             lockout;
   logic             lock_now;
   state_t           st     [2];
   state_t           st_n   [2];
   logic [CNT_W-1:0] tmr    [2];
   logic [CNT_W-1:0] tmr_n  [2];
   logic [1:0]       pulse;

   assign raw = {btn_mode, btn_down, btn_up};

   // Stage p0/p1: synchronisers; stage p2: debounced stable levels
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0   <= '0;
         sync_p1   <= '0;
         stable_p2 <= '0;
         stable_p3 <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0   <= raw;
         sync_p1   <= sync_p0;
         stable_p3 <= stable_p2;
         for (int i = 0; i < 3; i++) begin
            if (sync_p1[i] == stable_p2[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
               stable_p2[i] <= sync_p1[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise = stable_p2 & ~stable_p3;

   // Simultaneous up+down blocks both channels in the same cycle it is seen
   assign lock_now = lockout | (stable_p2[0] & stable_p2[1]);

   // Stage p3: auto-repeat next-state and pulse decode per up/down channel
   always_comb begin
      pulse = '0;
      for (int c = 0; c < 2; c++) begin
         st_n[c]  = st[c];
         tmr_n[c] = tmr[c];
         if (lock_now || !stable_p2[c]) begin
            st_n[c]  = ST_IDLE;
            tmr_n[c] = '0;
         end else begin
            case (st[c])
               ST_IDLE: begin
                  if (rise[c]) begin
                     pulse[c] = 1'b1;
                     st_n[c]  = ST_HOLD;
                     tmr_n[c] = CNT_W'(HOLD);
                  end
               end
               ST_HOLD, ST_REPEAT: begin
                  if (tmr[c] == CNT_W'(1)) begin
                     pulse[c] = 1'b1;
                     st_n[c]  = ST_REPEAT;
                     tmr_n[c] = CNT_W'(REPEAT);
                  end else begin
                     tmr_n[c] = tmr[c] - CNT_W'(1);
                  end
               end
               default: begin
                  st_n[c]  = ST_IDLE;
                  tmr_n[c] = '0;
               end
            endcase
         end
      end
   end

   // Stage p4: registered command outputs, lockout and mode level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            st[c]  <= ST_IDLE;
            tmr[c] <= '0;
         end
         up      <= 1'b0;
         down    <= 1'b0;
         mode    <= 1'b1;
         lockout <= 1'b0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            st[c]  <= st_n[c];
            tmr[c] <= tmr_n[c];
         end
         up   <= pulse[0];
         down <= pulse[1];
         if (stable_p2[0] & stable_p2[1]) lockout <= 1'b1;
         else if (!stable_p2[0] && !stable_p2[1]) lockout <= 1'b0;
         if (rise[2]) mode <= ~mode;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: latency, glitch rejection, repeat
// cadence, lockout, mode toggling and mid-operation reset.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic reset;
   logic btn_up, btn_down, btn_mode;
   logic up, down, mode;
   int   tests = 0;
   int   fails = 0;

   button_conditioner #(.DEBOUNCE(4), .HOLD(16), .REPEAT(8), .CNT_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_mode (btn_mode),
      .up       (up),
      .down     (down),
      .mode     (mode)
   );

   always #5 clk = ~clk;

   // Drive all buttons low and let any stable level settle.
   task automatic idle(input int n);
      btn_up = 0; btn_down = 0; btn_mode = 0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; btn_up = 0; btn_down = 0; btn_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (up !== 1'b0) begin fails++; $display("FAIL reset_up got=%b exp=0", up); end
      tests++;
      if (down !== 1'b0) begin fails++; $display("FAIL reset_down got=%b exp=0", down); end
      tests++;
      if (mode !== 1'b1) begin fails++; $display("FAIL reset_mode got=%b exp=1", mode); end
      reset = 0;
   endtask

   task automatic test_press();
      logic exp;
      btn_up = 1;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         exp = (k == 6);
         tests++;
         if (up !== exp) begin fails++; $display("FAIL press_up edge=%0d got=%b exp=%b", k, up, exp); end
         tests++;
         if (down !== 1'b0 || mode !== 1'b1) begin
            fails++; $display("FAIL press_side edge=%0d down=%b mode=%b exp down=0 mode=1", k, down, mode);
         end
         if (k == 9) btn_up = 0;
      end
      idle(10);
   endtask

   task automatic test_glitch();
      int pat [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      btn_up = 1'(pat[0]);
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         tests++;
         if (up !== 1'b0) begin fails++; $display("FAIL glitch_up edge=%0d got=%b exp=0", k, up); end
         btn_up = (k + 1 < 8) ? 1'(pat[k + 1]) : 1'b0;
      end
      idle(10);
   endtask

   task automatic test_repeat();
      logic exp;
      btn_down = 1;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         exp = (k == 6 || k == 22 || k == 30 || k == 38 || k == 46 || k == 54);
         tests++;
         if (down !== exp) begin fails++; $display("FAIL repeat_down edge=%0d got=%b exp=%b", k, down, exp); end
         tests++;
         if (up !== 1'b0) begin fails++; $display("FAIL repeat_up edge=%0d got=%b exp=0", k, up); end
         if (k == 55) btn_down = 0;
      end
      idle(10);
   endtask

   task automatic test_lockout();
      logic exp;
      btn_up = 1;
      for (int k = 0; k < 96; k++) begin
         @(posedge clk); #1;
         exp = (k == 6 || k == 22 || k == 86);
         tests++;
         if (up !== exp) begin fails++; $display("FAIL lock_up edge=%0d got=%b exp=%b", k, up, exp); end
         tests++;
         if (down !== 1'b0) begin fails++; $display("FAIL lock_down edge=%0d got=%b exp=0", k, down); end
         if (k == 19) btn_down = 1;
         if (k == 39) btn_down = 0;
         if (k == 59) btn_up = 0;
         if (k == 79) btn_up = 1;
      end
      idle(12);
   endtask

   task automatic test_mode();
      logic exp;
      btn_mode = 1;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         exp = (k < 6) ? 1'b1 : (k < 36) ? 1'b0 : (k < 66) ? 1'b1 : 1'b0;
         tests++;
         if (mode !== exp) begin fails++; $display("FAIL mode_level edge=%0d got=%b exp=%b", k, mode, exp); end
         tests++;
         if (up !== 1'b0 || down !== 1'b0) begin
            fails++; $display("FAIL mode_cmd edge=%0d up=%b down=%b exp 0 0", k, up, down);
         end
         btn_mode = ((k + 1) % 30) < 8;
      end
      idle(10);
   endtask

   task automatic test_reset_mid();
      logic exp;
      btn_up = 1;
      for (int k = 0; k <= 38; k++) begin
         @(posedge clk); #1;
      end
      tests++;
      if (up !== 1'b1) begin fails++; $display("FAIL midrst_prepulse got=%b exp=1", up); end
      #1 reset = 1;
      #1;
      tests++;
      if (up !== 1'b0) begin fails++; $display("FAIL midrst_up got=%b exp=0", up); end
      tests++;
      if (mode !== 1'b1 || down !== 1'b0) begin
         fails++; $display("FAIL midrst_state mode=%b down=%b exp mode=1 down=0", mode, down);
      end
      repeat (2) @(posedge clk);
      #2 reset = 0;
      for (int k = 0; k < 26; k++) begin
         @(posedge clk); #1;
         exp = (k == 6 || k == 22);
         tests++;
         if (up !== exp) begin fails++; $display("FAIL midrst_after edge=%0d got=%b exp=%b", k, up, exp); end
      end
      idle(10);
   endtask

   // Invariant watcher across the whole run
   always @(negedge clk) begin
      if (up === 1'b1 && down === 1'b1) begin
         tests++; fails++;
         $display("FAIL both_cmd up=%b down=%b exp not both 1", up, down);
      end
   end

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_repeat();
      test_lockout();
      test_mode();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
